grid_io_bank_param: RTL and testbench

- Parametrised successor to the fixed 8-subtile memory-bank IO tile.
- Holds NUM_PADS bidirectional GPIO subtiles whose mode bits live in an internal BL/WL config array, clocked by prog_clk.
- Adds row readback, a configuration-complete flag and optional synchronised inpad capture.
- Sits at the fabric edge between routing (outpad/inpad buses) and the chip pads.

---
 rtl/grid_io_bank_param_if.sv | 29 ++
 rtl/grid_io_bank_param.sv | 110 +++++++++++
 tb/tb_grid_io_bank_param.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/grid_io_bank_param_if.sv
// Routing/config-side bundle of the IO bank: BL/WL programming, row readback and the outpad/inpad buses.
// master drives programming and outpad; slave is the bank itself.
interface grid_io_bank_param_if #(
  parameter int NUM_PADS = 8,
  parameter int BL_WIDTH = 3,
  parameter int WL_WIDTH = 3,
  parameter int RD_ROW_W = 2
);
  logic                config_en;
  logic [BL_WIDTH-1:0] bl;
  logic [WL_WIDTH-1:0] wl;
  logic                rd_en;
  logic [RD_ROW_W-1:0] rd_row;
  logic [BL_WIDTH-1:0] rd_data;
  logic                rd_valid;
  logic                cfg_done;
  logic [NUM_PADS-1:0] outpad;
  logic [NUM_PADS-1:0] inpad;

  modport master (
    output config_en, bl, wl, rd_en, rd_row, outpad,
    input  rd_data, rd_valid, cfg_done, inpad
  );

  modport slave (
    input  config_en, bl, wl, rd_en, rd_row, outpad,
    output rd_data, rd_valid, cfg_done, inpad
  );
endinterface

// File: rtl/grid_io_bank_param.sv
// IO bank of NUM_PADS GPIO subtiles, mode bits in a BL/WL array; readback 1 cycle, inpad 0 cycles or 2 with GRID_IO_INPAD_SYNC_EN.
// No backpressure: a write and a read are accepted on every prog_clk edge.
module grid_io_bank_param #(
  parameter int NUM_PADS = 8,
  parameter int BL_WIDTH = 3,
  parameter int WL_WIDTH = 3,
  parameter int RD_ROW_W = 2
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset_n,
  grid_io_bank_param_if.slave  bus,
  inout  wire  [NUM_PADS-1:0]  gfpga_pad_GPIO_PAD
);
  localparam int ROWS_USED = (NUM_PADS + BL_WIDTH - 1) / BL_WIDTH;

  if (NUM_PADS > BL_WIDTH * WL_WIDTH) begin : g_size_chk
    $fatal(1, "grid_io_bank_param: NUM_PADS exceeds BL_WIDTH*WL_WIDTH");
  end
  if ((1 << RD_ROW_W) < WL_WIDTH) begin : g_row_w_chk
    $fatal(1, "grid_io_bank_param: RD_ROW_W too narrow for WL_WIDTH");
  end

  // Reset asserts asynchronously, releases two prog_clk edges later.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) rst_sync <= '0;
    else               rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [NUM_PADS-1:0]  cfg;
  logic [ROWS_USED-1:0] row_written;
  logic                 cfg_done_q;
  logic [BL_WIDTH-1:0]  rd_data_q;
  logic                 rd_valid_q;
  logic [BL_WIDTH-1:0]  row_dat;

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg         <= '0;
      row_written <= '0;
      cfg_done_q  <= 1'b0;
    end else begin
      if (bus.config_en) begin
        for (int i = 0; i < NUM_PADS; i++) begin
          if (bus.wl[i / BL_WIDTH]) cfg[i] <= bus.bl[i % BL_WIDTH];
        end
        for (int r = 0; r < ROWS_USED; r++) begin
          if (bus.wl[r]) row_written[r] <= 1'b1;
        end
      end
      if (&row_written) cfg_done_q <= 1'b1;
    end
  end

  // Only implemented cells contribute; unimplemented and out-of-range rows read as 0.
  always_comb begin
    row_dat = '0;
    for (int b = 0; b < BL_WIDTH; b++) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if ((i % BL_WIDTH) == b && int'(bus.rd_row) == (i / BL_WIDTH)) row_dat[b] = cfg[i];
      end
    end
  end

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= row_dat;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.cfg_done = cfg_done_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    assign gfpga_pad_GPIO_PAD[i] = cfg[i] ? bus.outpad[i] : 1'bz;
  end

  logic [NUM_PADS-1:0] pad_in;

`ifdef GRID_IO_INPAD_SYNC_EN
  logic [NUM_PADS-1:0] pad_sync1;
  logic [NUM_PADS-1:0] pad_sync2;

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_sync1 <= '0;
      pad_sync2 <= '0;
    end else begin
      pad_sync1 <= gfpga_pad_GPIO_PAD;
      pad_sync2 <= pad_sync1;
    end
  end

  assign pad_in = pad_sync2;
`else
  assign pad_in = gfpga_pad_GPIO_PAD;
`endif

  // Output-mode gate sits after any synchroniser so mode changes take effect at once.
  assign bus.inpad = pad_in & ~cfg;
endmodule

// File: tb/tb_grid_io_bank_param.sv
// Directed bench for grid_io_bank_param (8 pads, 3x3 array); readbacks are checked by a queue-based monitor.
module tb_grid_io_bank_param;
  logic       clk;
  logic       rst_n;
  logic [7:0] tb_oe;
  logic [7:0] tb_val;
  wire  [7:0] pad;
  int         checks;
  int         errors;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  grid_io_bank_param_if #(.NUM_PADS(8), .BL_WIDTH(3), .WL_WIDTH(3), .RD_ROW_W(2)) bus ();

  grid_io_bank_param #(.NUM_PADS(8), .BL_WIDTH(3), .WL_WIDTH(3), .RD_ROW_W(2)) dut (
    .prog_clk           (clk),
    .prog_reset_n       (rst_n),
    .bus                (bus),
    .gfpga_pad_GPIO_PAD (pad)
  );

  for (genvar i = 0; i < 8; i++) begin : g_tb_pad
    assign pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] row, input logic [2:0] exp);
    bus.rd_en  = 1'b1;
    bus.rd_row = row;
    exp_q.push_back(exp);
    tick();
  endtask

  task automatic wr(input logic [2:0] wl, input logic [2:0] bl);
    bus.config_en = 1'b1;
    bus.wl        = wl;
    bus.bl        = bl;
    tick();
    bus.config_en = 1'b0;
    bus.wl        = 3'b000;
  endtask

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_strobe: rd_valid with data %0h, expected no strobe", bus.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rd_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", bus.rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.config_en = 1'b0;
    bus.bl        = '0;
    bus.wl        = '0;
    bus.rd_en     = 1'b0;
    bus.rd_row    = '0;
    bus.outpad    = '0;
    tb_oe         = 8'hFF;
    tb_val        = 8'h00;

    // Reset state, pads pulled low.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_inpad", bus.inpad, 8'h00);
    check("rst_rd_valid", 8'(bus.rd_valid), 8'h00);
    check("rst_cfg_done", 8'(bus.cfg_done), 8'h00);
    check("rst_rd_data", 8'(bus.rd_data), 8'h00);
    tb_val = 8'hFF;
    repeat (2) tick();
    check("rst_inpad_high", bus.inpad, 8'hFF);

    // Single-row write: pads 0 and 2 become outputs.
    tb_oe      = 8'hFA;
    bus.outpad = 8'h04;
    wr(3'b001, 3'b101);
    #1;
    check("row0_pad0", 8'(pad[0]), 8'h00);
    check("row0_pad2", 8'(pad[2]), 8'h01);
    check("row0_pad1_z", 8'(pad[1]), 8'h01);
    check("row0_inpad_gate", bus.inpad, 8'hFA);
    rd(2'd0, 3'b101);
    bus.rd_en = 1'b0;
    tb_oe     = 8'h00;

    // Fill all rows; cfg_done one edge after the last row.
    wr(3'b001, 3'b101);
    wr(3'b010, 3'b010);
    wr(3'b100, 3'b110);
    check("cfg_done_early", 8'(bus.cfg_done), 8'h00);
    tick();
    check("cfg_done_set", 8'(bus.cfg_done), 8'h01);
    bus.config_en = 1'b0;
    bus.wl        = 3'b111;
    bus.bl        = 3'b000;
    tick();
    bus.wl = 3'b000;
    rd(2'd0, 3'b101);
    rd(2'd1, 3'b010);
    rd(2'd2, 3'b010);
    bus.rd_en  = 1'b0;
    bus.outpad = 8'hF0;
    #1;
    check("gated_pads", pad & 8'h95, 8'h90);

    // Broadcast to every row; position 8 has no cell and reads 0.
    wr(3'b111, 3'b111);
    bus.outpad = 8'h3C;
    #1;
    check("bcast_pads", pad, 8'h3C);
    check("bcast_inpad", bus.inpad, 8'h00);
    check("bcast_cfg_done", 8'(bus.cfg_done), 8'h01);
    rd(2'd2, 3'b011);
    bus.rd_en = 1'b0;

    // Same-edge read/write returns old data; out-of-range row reads 0.
    bus.config_en = 1'b1;
    bus.wl        = 3'b001;
    bus.bl        = 3'b000;
    rd(2'd0, 3'b111);
    bus.config_en = 1'b0;
    bus.wl        = 3'b000;
    rd(2'd0, 3'b000);
    rd(2'd1, 3'b111);
    rd(2'd3, 3'b000);
    rd(2'd2, 3'b011);
    bus.rd_en = 1'b0;
    tick();
    check("idle_rd_valid", 8'(bus.rd_valid), 8'h00);
    check("idle_rd_hold", 8'(bus.rd_data), 8'h03);

    // Inpad latency on pads 0..2 (input mode again).
    tb_oe  = 8'h07;
    tb_val = 8'h00;
    repeat (3) tick();
    check("lat_inpad_low", bus.inpad, 8'h00);
    tb_val = 8'h07;
    #1;
`ifdef GRID_IO_INPAD_SYNC_EN
    check("lat_sync_e0", bus.inpad, 8'h00);
    tick();
    check("lat_sync_e1", bus.inpad, 8'h00);
    tick();
    check("lat_sync_e2", bus.inpad, 8'h07);
`else
    check("lat_comb", bus.inpad, 8'h07);
`endif

    // Reset while pads drive and a read is pending.
    tb_oe = 8'h00;
    tick();
    wr(3'b111, 3'b111);
    bus.outpad = 8'hA5;
    bus.rd_en  = 1'b1;
    bus.rd_row = 2'd1;
    #1;
    check("pre_rst_pads", pad, 8'hA5);
    rst_n = 1'b0;
    #1;
    tb_oe  = 8'hFF;
    tb_val = 8'h5A;
    #1;
    check("mid_rst_pads_z", pad, 8'h5A);
    check("mid_rst_cfg_done", 8'(bus.cfg_done), 8'h00);
    repeat (2) tick();
    check("mid_rst_rd_valid", 8'(bus.rd_valid), 8'h00);
    check("mid_rst_rd_data", 8'(bus.rd_data), 8'h00);
    bus.rd_en = 1'b0;

    check("rd_queue_left", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
